// File: rtl/pio_panel_pkg.sv
// Shared constants for pio_panel_ctrl: register map, SEG_CTRL field layout
// and the hex font used by the 7-segment scanner.
package pio_panel_pkg;

   localparam logic [2:0] ADDR_LED      = 3'd0;
   localparam logic [2:0] ADDR_SEG_DATA = 3'd1;
   localparam logic [2:0] ADDR_SEG_CTRL = 3'd2;
   localparam logic [2:0] ADDR_SWITCH   = 3'd3;
   localparam logic [2:0] ADDR_KEY      = 3'd4;
   localparam logic [2:0] ADDR_EDGE     = 3'd5;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

   localparam int SEG_EN_BIT    = 0;
   localparam int SEG_DP_LSB    = 8;
   localparam int SEG_BLANK_LSB = 16;

   // Active-high segments {g,f,e,d,c,b,a}; b and d use the lowercase glyphs.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser plus a stability counter that only
// accepts a new level after DEB_CYC consecutive differing samples.
module key_debounce
   import pio_panel_pkg::*;
#(
   parameter int DEB_CYC = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_n,
   output logic level,
   output logic press_pulse
);

   localparam int CW = $clog2(DEB_CYC);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;

   always_comb begin
      sync_d  = {sync_q[0], raw_n};
      level_d = level_q;
      cnt_d   = '0;
      accept  = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CW'(DEB_CYC - 1)) begin
            accept  = 1'b1;
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level       = level_q;
   assign press_pulse = accept & ~sync_q[1];

   // Sync chain and level reset to "released" so reset never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/pio_panel_ctrl.sv
// Avalon-MM panel PIO: LED bank, scanned hex 7-segment display, synchronised
// switches and debounced keys with sticky press capture and maskable IRQ.
module pio_panel_ctrl
   import pio_panel_pkg::*;
#(
   parameter int LED_W    = 8,
   parameter int SW_W     = 5,
   parameter int KEY_W    = 2,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000,
   parameter int DEB_CYC  = 1000000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          avs_address,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [31:0]         avs_readdata,
   output logic                irq,
   output logic [LED_W-1:0]    led,
   output logic [DIGITS+7:0]   seg_output,
   input  logic [SW_W-1:0]     switch,
   input  logic [KEY_W-1:0]    key
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [LED_W-1:0]    led_q, led_d;
   logic [4*DIGITS-1:0] seg_data_q, seg_data_d;
   logic                en_q, en_d;
   logic [DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d;
   logic [KEY_W-1:0]    edge_q, edge_d, mask_q, mask_d, edge_w1c;
   logic                irq_q, irq_d;
   logic [31:0]         rdata_q, rdata_d, rd_val;
   logic [SW_W-1:0]     sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DIGITS+7:0]   seg_q, seg_d;
   logic [KEY_W-1:0]    key_level, key_press;
   logic [3:0]          nibble;
   logic                dp_sel, blank_sel;
   logic                unused_wd;

   assign unused_wd = ^avs_writedata;

   for (genvar i = 0; i < KEY_W; i++) begin : g_key
      key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk         (clk),
         .reset_n     (reset_n),
         .raw_n       (key[i]),
         .level       (key_level[i]),
         .press_pulse (key_press[i])
      );
   end

   // Read mux samples pre-write state, so a same-cycle write reads back old data.
   always_comb begin
      rd_val = '0;
      case (avs_address)
         ADDR_LED:      rd_val[LED_W-1:0]    = led_q;
         ADDR_SEG_DATA: rd_val[4*DIGITS-1:0] = seg_data_q;
         ADDR_SEG_CTRL: begin
            rd_val[SEG_EN_BIT]              = en_q;
            rd_val[SEG_DP_LSB +: DIGITS]    = dp_q;
            rd_val[SEG_BLANK_LSB +: DIGITS] = blank_q;
         end
         ADDR_SWITCH:   rd_val[SW_W-1:0]     = sw_s2_q;
         ADDR_KEY:      rd_val[KEY_W-1:0]    = ~key_level;
         ADDR_EDGE:     rd_val[KEY_W-1:0]    = edge_q;
         ADDR_IRQ_MASK: rd_val[KEY_W-1:0]    = mask_q;
         default:       rd_val               = '0;
      endcase
      rdata_d = avs_read ? rd_val : rdata_q;
   end

   always_comb begin
      led_d      = led_q;
      seg_data_d = seg_data_q;
      en_d       = en_q;
      dp_d       = dp_q;
      blank_d    = blank_q;
      mask_d     = mask_q;
      edge_w1c   = '0;
      sw_s1_d    = switch;
      sw_s2_d    = sw_s1_q;
      if (avs_write) begin
         case (avs_address)
            ADDR_LED:      led_d      = avs_writedata[LED_W-1:0];
            ADDR_SEG_DATA: seg_data_d = avs_writedata[4*DIGITS-1:0];
            ADDR_SEG_CTRL: begin
               en_d    = avs_writedata[SEG_EN_BIT];
               dp_d    = avs_writedata[SEG_DP_LSB +: DIGITS];
               blank_d = avs_writedata[SEG_BLANK_LSB +: DIGITS];
            end
            ADDR_EDGE:     edge_w1c   = avs_writedata[KEY_W-1:0];
            ADDR_IRQ_MASK: mask_d     = avs_writedata[KEY_W-1:0];
            default: ;
         endcase
      end
      // A press landing in the same cycle as its W1C must not be lost.
      edge_d = (edge_q & ~edge_w1c) | key_press;
      irq_d  = |(edge_q & mask_q);
   end

   always_comb begin
      presc_d   = '0;
      idx_d     = '0;
      seg_d     = '1;
      nibble    = '0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nibble    = seg_data_q[4*i +: 4];
            dp_sel    = dp_q[i];
            blank_sel = blank_q[i];
         end
      end
      if (en_q) begin
         if (presc_q == PW'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
            idx_d   = idx_q;
         end
         for (int i = 0; i < DIGITS; i++) begin
            seg_d[8+i] = (idx_q != IW'(i));
         end
         if (!blank_sel) begin
            seg_d[7:0] = {~dp_sel, ~HEX_SEG[nibble]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_q      <= '0;
         seg_data_q <= '0;
         en_q       <= 1'b0;
         dp_q       <= '0;
         blank_q    <= '0;
         edge_q     <= '0;
         mask_q     <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         presc_q    <= '0;
         idx_q      <= '0;
         seg_q      <= '1;
      end else begin
         led_q      <= led_d;
         seg_data_q <= seg_data_d;
         en_q       <= en_d;
         dp_q       <= dp_d;
         blank_q    <= blank_d;
         edge_q     <= edge_d;
         mask_q     <= mask_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
         sw_s1_q    <= sw_s1_d;
         sw_s2_q    <= sw_s2_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
      end
   end

   assign led          = led_q;
   assign irq          = irq_q;
   assign avs_readdata = rdata_q;
   assign seg_output   = seg_q;

endmodule
